no_tgfbr_multi: RTL

- Parametrised gene-regulatory-network node.
- Holds NUM_CH independent copies of one Boolean state bit, one per simulation stream.
- Each copy evaluates its own activator/inhibitor inputs and updates on its start strobe, optionally at a divided rate.
- Sits in the GNR node array; s feeds back into the interconnect that drives other nodes' inputs.

---
 rtl/gnr_node_pkg.sv | 16 +
 rtl/no_tgfbr_div.sv | 41 ++++
 rtl/no_tgfbr_multi.sv | 98 +++++++++
 3 files changed

// File: rtl/gnr_node_pkg.sv
// Shared constants and the next-state reduction for the GNR node.
package gnr_node_pkg;

  localparam int MODE_OR      = 0;
  localparam int MODE_ACT_INH = 1;

  localparam int DEF_DIV_W = 4;
  localparam int DEF_CNT_W = 16;

  // Boolean rule of the node, applied to already-reduced activator/inhibitor ORs.
  function automatic logic node_next(input int mode, input logic any_act, input logic any_inh);
    if (mode == MODE_ACT_INH) return any_act & ~any_inh;
    return any_act;
  endfunction

endpackage

// File: rtl/no_tgfbr_div.sv
// Per-channel update divider: fires on the first start after load, then every div+1 starts.
module no_tgfbr_div
  import gnr_node_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  input  logic             start,
  output logic             fire
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q, cnt_d;

  // load masks start, so a start coinciding with re-initialise never fires
  assign fire = start & ~load & (cnt_q == '0);

  // Down-counter: reload with the divisor on a firing start, else count down; never below 0
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = '0;
    else if (start)
      cnt_d = (cnt_q == '0) ? div_q : cnt_q - 1'b1;
  end

  // Divisor is captured only on load and held until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (load) div_q <= div;
    end
  end

endmodule

// File: rtl/no_tgfbr_multi.sv
// Multi-channel GRN node: NUM_CH independent Boolean state bits with divided update rate.
// Optional per-channel transition counter enabled by macro GNR_NODE_TRANS_CNT_EN.
module no_tgfbr_multi
  import gnr_node_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int NUM_ACT = 1,
  parameter int NUM_INH = 1,
  parameter int MODE    = MODE_OR,
  parameter int DIV_W   = DEF_DIV_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      reset_nos,
  input  logic                      init_state,
  input  logic [NUM_CH*DIV_W-1:0]   div_cfg,
  input  logic [NUM_CH-1:0]         start,
  input  logic [NUM_CH*NUM_ACT-1:0] act_in,
  input  logic [NUM_CH*NUM_INH-1:0] inh_in,
  output logic [NUM_CH-1:0]         s,
  output logic [NUM_CH-1:0]         s_fb,
  output logic [NUM_CH-1:0]         changed,
  output logic [NUM_CH*CNT_W-1:0]   trans_cnt
);

  logic [NUM_CH-1:0] fire;
  logic [NUM_CH-1:0] f;
  logic [NUM_CH-1:0] s_q, s_d;
  logic [NUM_CH-1:0] chg_q, chg_d;

  // One divider and one next-state reduction per channel
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    no_tgfbr_div #(.DIV_W(DIV_W)) u_div (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (reset_nos),
      .div   (div_cfg[c*DIV_W +: DIV_W]),
      .start (start[c]),
      .fire  (fire[c])
    );
    assign f[c] = node_next(MODE, |act_in[c*NUM_ACT +: NUM_ACT], |inh_in[c*NUM_INH +: NUM_INH]);
  end

  // Next state: re-initialise wins; otherwise only firing channels take f
  always_comb begin
    s_d   = s_q;
    chg_d = '0;
    if (reset_nos) begin
      s_d = {NUM_CH{init_state}};
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (fire[c]) begin
          s_d[c]   = f[c];
          chg_d[c] = f[c] ^ s_q[c];
        end
      end
    end
  end

  // State and change-pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q   <= '0;
      chg_q <= '0;
    end else begin
      s_q   <= s_d;
      chg_q <= chg_d;
    end
  end

  assign s       = s_q;
  assign s_fb    = s_q;
  assign changed = chg_q;

`ifdef GNR_NODE_TRANS_CNT_EN
  logic [NUM_CH-1:0][CNT_W-1:0] tc_q;

  // Count change pulses, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (reset_nos)
          tc_q[c] <= '0;
        else if (chg_q[c] && (tc_q[c] != '1))
          tc_q[c] <= tc_q[c] + 1'b1;
      end
    end
  end

  assign trans_cnt = tc_q;
`else
  assign trans_cnt = '0;
`endif

endmodule
